// File: rtl/cmp_frame_pkg.sv
// rtl/cmp_frame_pkg.sv - shared widths and FSM encoding for the frame min/max stage
package cmp_frame_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int IDX_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/mag_cmp.sv
// rtl/mag_cmp.sv - unsigned magnitude comparator, a versus b
module mag_cmp #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              eq_o,
    output logic              gt_o
);

    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i > b_i);

endmodule

// File: rtl/cmp_frame_minmax.sv
// rtl/cmp_frame_minmax.sv - per-frame min/max/index/length resolver; CMP_FRAME_TIE_LAST_EN selects last-occurrence indices on ties
module cmp_frame_minmax
    import cmp_frame_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_min,
    output logic [DATA_W-1:0] res_max,
    output logic [IDX_W-1:0]  res_min_idx,
    output logic [IDX_W-1:0]  res_max_idx,
    output logic [IDX_W-1:0]  res_len,
    output logic              res_ovf
);

    localparam logic [IDX_W-1:0] CNT_MAX = '1;
    localparam logic [IDX_W-1:0] CNT_ONE = IDX_W'(1);

    state_e state_q, state_d;

    logic [DATA_W-1:0] min_q, min_d, max_q, max_d;
    logic [IDX_W-1:0]  min_idx_q, min_idx_d, max_idx_q, max_idx_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] res_min_q, res_min_d, res_max_q, res_max_d;
    logic [IDX_W-1:0]  res_min_idx_q, res_min_idx_d, res_max_idx_q, res_max_idx_d;
    logic [IDX_W-1:0]  res_len_q, res_len_d;
    logic              res_ovf_q, res_ovf_d;
    logic              res_valid_q, res_valid_d;

    logic max_eq, max_gt, min_eq, min_gt;
    logic upd_max_idx, upd_min_idx;
    logic accept;

    // max side: in_data > max ; min side: min > in_data
    mag_cmp #(.DATA_W(DATA_W)) u_cmp_max (
        .a_i  (in_data),
        .b_i  (max_q),
        .eq_o (max_eq),
        .gt_o (max_gt)
    );

    mag_cmp #(.DATA_W(DATA_W)) u_cmp_min (
        .a_i  (min_q),
        .b_i  (in_data),
        .eq_o (min_eq),
        .gt_o (min_gt)
    );

`ifdef CMP_FRAME_TIE_LAST_EN
    assign upd_max_idx = max_gt | max_eq;
    assign upd_min_idx = min_gt | min_eq;
`else
    logic unused_eq;
    assign unused_eq   = max_eq ^ min_eq;
    assign upd_max_idx = max_gt;
    assign upd_min_idx = min_gt;
`endif

    assign in_ready = (state_q != HOLD);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d       = state_q;
        min_d         = min_q;
        max_d         = max_q;
        min_idx_d     = min_idx_q;
        max_idx_d     = max_idx_q;
        cnt_d         = cnt_q;
        ovf_d         = ovf_q;
        res_min_d     = res_min_q;
        res_max_d     = res_max_q;
        res_min_idx_d = res_min_idx_q;
        res_max_idx_d = res_max_idx_q;
        res_len_d     = res_len_q;
        res_ovf_d     = res_ovf_q;
        res_valid_d   = res_valid_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    min_d     = in_data;
                    max_d     = in_data;
                    min_idx_d = '0;
                    max_idx_d = '0;
                    cnt_d     = CNT_ONE;
                    ovf_d     = 1'b0;
                    state_d   = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    // cnt_q never exceeds CNT_MAX, so it doubles as the saturated index
                    if (max_gt)      max_d     = in_data;
                    if (upd_max_idx) max_idx_d = cnt_q;
                    if (min_gt)      min_d     = in_data;
                    if (upd_min_idx) min_idx_d = cnt_q;
                    if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                    else                  cnt_d = cnt_q + CNT_ONE;
                    if (in_last) state_d = HOLD;
                end
            end
            HOLD: begin
                if (!res_valid_q) begin
                    res_valid_d   = 1'b1;
                    res_min_d     = min_q;
                    res_max_d     = max_q;
                    res_min_idx_d = min_idx_q;
                    res_max_idx_d = max_idx_q;
                    res_len_d     = cnt_q;
                    res_ovf_d     = ovf_q;
                end else if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            min_q         <= '0;
            max_q         <= '0;
            min_idx_q     <= '0;
            max_idx_q     <= '0;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            res_min_q     <= '0;
            res_max_q     <= '0;
            res_min_idx_q <= '0;
            res_max_idx_q <= '0;
            res_len_q     <= '0;
            res_ovf_q     <= 1'b0;
            res_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            min_q         <= min_d;
            max_q         <= max_d;
            min_idx_q     <= min_idx_d;
            max_idx_q     <= max_idx_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
            res_min_q     <= res_min_d;
            res_max_q     <= res_max_d;
            res_min_idx_q <= res_min_idx_d;
            res_max_idx_q <= res_max_idx_d;
            res_len_q     <= res_len_d;
            res_ovf_q     <= res_ovf_d;
            res_valid_q   <= res_valid_d;
        end
    end

    assign res_valid   = res_valid_q;
    assign res_min     = res_min_q;
    assign res_max     = res_max_q;
    assign res_min_idx = res_min_idx_q;
    assign res_max_idx = res_max_idx_q;
    assign res_len     = res_len_q;
    assign res_ovf     = res_ovf_q;

endmodule

// File: tb/tb_cmp_frame_minmax.sv
// tb/tb_cmp_frame_minmax.sv - scoreboard bench for cmp_frame_minmax (honours CMP_FRAME_TIE_LAST_EN)
module tb_cmp_frame_minmax;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'd0;
    logic       in_last = 1'b0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_min, res_max, res_min_idx, res_max_idx, res_len;
    logic       res_ovf;

    cmp_frame_minmax #(.DATA_W(8), .IDX_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_min     (res_min),
        .res_max     (res_max),
        .res_min_idx (res_min_idx),
        .res_max_idx (res_max_idx),
        .res_len     (res_len),
        .res_ovf     (res_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mn, mx, mn_i, mx_i, len, ovf, acc_edge;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   hs_edge = -10;
    int   hold_n = 0;
    bit   rand_ready = 1'b0;
    bit   bubbles = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int sat(input int i);
        return (i > 255) ? 255 : i;
    endfunction

    // Reference: whole-frame view; indices are sample positions clamped to 255
    function automatic exp_t model(input int v[$], input int acc_edge);
        exp_t e;
        e.mn = v[0];
        e.mx = v[0];
        foreach (v[i]) begin
            if (v[i] < e.mn) e.mn = v[i];
            if (v[i] > e.mx) e.mx = v[i];
        end
        e.mn_i = -1;
        e.mx_i = -1;
        foreach (v[i]) begin
`ifdef CMP_FRAME_TIE_LAST_EN
            if (v[i] == e.mn) e.mn_i = sat(i);
            if (v[i] == e.mx) e.mx_i = sat(i);
`else
            if (v[i] == e.mn && e.mn_i < 0) e.mn_i = sat(i);
            if (v[i] == e.mx && e.mx_i < 0) e.mx_i = sat(i);
`endif
        end
        e.len      = sat(v.size());
        e.ovf      = (v.size() > 255) ? 1 : 0;
        e.acc_edge = acc_edge;
        return e;
    endfunction

    // Called at a negedge; returns at a negedge with in_valid low
    task automatic send(input int v[$], input bit has_last, output int first_edge);
        int acc = 0;
        first_edge = -1;
        for (int i = 0; i < v.size(); i++) begin
            if (bubbles && ($urandom % 4 == 0)) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = 8'(v[i]);
            in_last  = has_last && (i == v.size() - 1);
            for (int t = 0; !in_ready; t++) begin
                if (t > 1000) begin
                    chk("in_ready_timeout", 0, 1);
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                    return;
                end
                @(negedge clk);
            end
            acc = cyc + 1;
            if (i == 0) first_edge = acc;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (has_last) sb.push_back(model(v, acc));
    endtask

    task automatic drain();
        for (int t = 0; (sb.size() != 0 || res_valid); t++) begin
            if (t > 2000) begin
                chk("drain_timeout", sb.size(), 0);
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (hold_n > 0) begin
                res_ready = 1'b0;
                hold_n--;
            end else begin
                res_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
            end
        end
    end

    initial begin
        exp_t cur;
        bit   prev_v = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (res_valid) begin
                    chk("in_ready_low_in_hold", in_ready, 0);
                    if (!prev_v) begin
                        chk("sb_nonempty", (sb.size() != 0) ? 1 : 0, 1);
                        if (sb.size() != 0) begin
                            cur = sb.pop_front();
                            chk("latency", cyc, cur.acc_edge + 1);
                        end
                    end
                    chk("res_min", res_min, cur.mn);
                    chk("res_max", res_max, cur.mx);
                    chk("res_min_idx", res_min_idx, cur.mn_i);
                    chk("res_max_idx", res_max_idx, cur.mx_i);
                    chk("res_len", res_len, cur.len);
                    chk("res_ovf", res_ovf, cur.ovf);
                    if (res_ready) hs_edge = cyc + 1;
                end
                prev_v = res_valid;
            end
        end
    end

    initial begin
        int v[$];
        int fe;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_min", res_min, 0);
        chk("rst_res_max", res_max, 0);
        chk("rst_res_len", res_len, 0);
        chk("rst_res_ovf", res_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);

        v = '{100, 20, 56, 233, 11};
        send(v, 1'b1, fe);
        v = '{45, 45, 45};
        send(v, 1'b1, fe);
        drain();

        hold_n = 8;
        v = '{7};
        send(v, 1'b1, fe);
        drain();

        v = {};
        for (int i = 0; i < 300; i++) v.push_back(i % 256);
        send(v, 1'b1, fe);

        rand_ready = 1'b1;
        v = '{3, 9};
        send(v, 1'b1, fe);
        v = '{4};
        send(v, 1'b1, fe);
        chk("b2b_accept_edge", fe, hs_edge + 1);
        drain();

        v = '{1, 200};
        send(v, 1'b0, fe);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_min", res_min, 0);
        chk("mid_rst_max", res_max, 0);
        chk("mid_rst_min_idx", res_min_idx, 0);
        chk("mid_rst_max_idx", res_max_idx, 0);
        chk("mid_rst_len", res_len, 0);
        chk("mid_rst_ovf", res_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        v = '{5, 6};
        send(v, 1'b1, fe);
        drain();

        bubbles = 1'b1;
        for (int f = 0; f < 25; f++) begin
            int n;
            n = $urandom_range(1, 10);
            v = {};
            for (int i = 0; i < n; i++) v.push_back($urandom_range(0, 15));
            send(v, 1'b1, fe);
        end
        drain();
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
